// File: rtl/ask4_downsample_slicer.sv
// ask4_downsample_slicer: keeps one matched-filter sample per symbol at a
// selectable phase, slices it to a 4-ASK decision against an adaptive
// reference level, and reports the slicer error.
module ask4_downsample_slicer #(
  parameter int SPS      = 4,
  parameter int LOG2_AVG = 4,
  parameter int INIT_REF = 65536
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk_en,
  input  logic               sam_clk_en,
  input  logic [1:0]         phase,
  input  logic signed [17:0] x_in,
  output logic [1:0]         sym_out,
  output logic               sym_valid,
  output logic signed [17:0] ref_level,
  output logic               ref_valid,
  output logic signed [17:0] err
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int AW = 18 + LOG2_AVG;

  logic [CW-1:0]       cnt, idx, cnt_next;
  logic                capture, cap_d;
  logic signed [17:0]  samp;
  logic [AW-1:0]       acc, acc_sum, avg;
  logic [LOG2_AVG-1:0] nsym;

  logic signed [19:0]  s20, r20, r_half, r_3half, recon, diff;
  logic [1:0]          dec;
  logic signed [17:0]  err_sat;
  logic [17:0]         mag;

  // Sample index within the symbol and capture decision for this strobe
  always_comb begin
    idx      = sym_clk_en ? '0 : cnt;
    capture  = sam_clk_en && (idx == CW'(phase));
    cnt_next = (idx == CW'(SPS - 1)) ? '0 : idx + CW'(1);
  end

  // Slice the captured sample, reconstruct its level and form the error
  always_comb begin
    s20     = {{2{samp[17]}}, samp};
    r20     = {{2{ref_level[17]}}, ref_level};
    r_half  = r20 >>> 1;
    r_3half = r20 + r_half;
    if (s20 >= r20)              dec = 2'b11;
    else if (s20 >= 20'sd0)      dec = 2'b10;
    else if (s20 > -r20)         dec = 2'b01;
    else                         dec = 2'b00;
    case (dec)
      2'b11:   recon = r_3half;
      2'b10:   recon = r_half;
      2'b01:   recon = -r_half;
      default: recon = -r_3half;
    endcase
    diff = s20 - recon;
    if (diff > 20'sd131071)       err_sat = 18'sh1FFFF;
    else if (diff < -20'sd131072) err_sat = 18'sh20000;
    else                          err_sat = diff[17:0];
  end

  // Magnitude for the reference average; the most negative code clamps
  always_comb begin
    if (!samp[17])                mag = samp;
    else if (samp == 18'sh20000)  mag = 18'h1FFFF;
    else                          mag = 18'(-samp);
    acc_sum = acc + AW'(mag);
    avg     = acc_sum >> LOG2_AVG;
  end

  // Phase counter, capture register, registered slicer and reference tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      samp      <= '0;
      cap_d     <= 1'b0;
      acc       <= '0;
      nsym      <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      err       <= '0;
      ref_level <= $signed(18'(INIT_REF));
      ref_valid <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      cap_d     <= capture;
      if (sam_clk_en) cnt <= cnt_next;
      if (capture)    samp <= x_in;
      // The slice of a capture uses the pre-update ref_level; a newly
      // averaged level only reaches the next capture's decision.
      if (cap_d) begin
        sym_out   <= dec;
        err       <= err_sat;
        sym_valid <= 1'b1;
        nsym      <= nsym + LOG2_AVG'(1);
        if (nsym == '1) begin
          ref_level <= $signed(avg[17:0]);
          ref_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_ask4_downsample_slicer.sv
// Directed self-checking bench for ask4_downsample_slicer.
module tb_ask4_downsample_slicer;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               sym_clk_en = 1'b0;
  logic               sam_clk_en = 1'b0;
  logic [1:0]         phase = 2'd0;
  logic signed [17:0] x_in = '0;
  logic [1:0]         sym_out;
  logic               sym_valid;
  logic signed [17:0] ref_level;
  logic               ref_valid;
  logic signed [17:0] err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0]         q_sym[$];
  logic signed [17:0] q_err[$];
  int                 q_cyc[$];

  ask4_downsample_slicer #(.SPS(4), .LOG2_AVG(4), .INIT_REF(65536)) dut (
    .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .sam_clk_en(sam_clk_en),
    .phase(phase), .x_in(x_in), .sym_out(sym_out), .sym_valid(sym_valid),
    .ref_level(ref_level), .ref_valid(ref_valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (sym_valid === 1'b1) begin
      q_sym.push_back(sym_out);
      q_err.push_back(err);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // One sample strobe; called at a negedge, returns at the next negedge
  task automatic strobe(input logic sym, input logic signed [17:0] x);
    sam_clk_en = 1'b1;
    sym_clk_en = sym;
    x_in       = x;
    @(negedge clk);
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
  endtask

  task automatic send_sym(input logic signed [17:0] x0, input logic signed [17:0] x1,
                          input logic signed [17:0] x2, input logic signed [17:0] x3);
    strobe(1'b1, x0);
    strobe(1'b0, x1);
    strobe(1'b0, x2);
    strobe(1'b0, x3);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q_sym.delete(); q_err.delete(); q_cyc.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (sym_out !== 2'd0 || sym_valid !== 1'b0 || err !== 18'sd0) begin
      errors++;
      $display("FAIL reset_out: got sym=%0d v=%0b err=%0d expected 0 0 0", sym_out, sym_valid, err);
    end
    checks++;
    if (ref_level !== 18'sd65536 || ref_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ref: got ref=%0d rv=%0b expected 65536 0", ref_level, ref_valid);
    end
  endtask

  task automatic test_timing();
    phase = 2'd0;
    q_sym.delete(); q_err.delete(); q_cyc.delete();
    strobe(1'b1, 18'sd98304);
    checks++;
    if (sym_valid !== 1'b0) begin
      errors++; $display("FAIL valid_early: got %0b expected 0", sym_valid);
    end
    @(negedge clk);
    checks++;
    if (sym_valid !== 1'b1 || sym_out !== 2'b11 || err !== 18'sd0) begin
      errors++;
      $display("FAIL timing_result: got v=%0b sym=%0d err=%0d expected 1 3 0", sym_valid, sym_out, err);
    end
    strobe(1'b0, 18'sd0);
    checks++;
    if (sym_valid !== 1'b0) begin
      errors++; $display("FAIL valid_width: got %0b expected 0", sym_valid);
    end
    strobe(1'b0, 18'sd0);
    strobe(1'b0, 18'sd0);
    send_sym(18'sd98304, 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (q_sym.size() != 2) begin
      errors++; $display("FAIL pulse_count: got %0d expected 2", q_sym.size());
    end
  endtask

  task automatic test_levels();
    logic signed [17:0] xs[4] = '{-18'sd98304, -18'sd32768, 18'sd32768, 18'sd98304};
    q_sym.delete(); q_err.delete(); q_cyc.delete();
    for (int i = 0; i < 4; i++) send_sym(xs[i], 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (q_sym.size() != 4) begin
      errors++; $display("FAIL levels_count: got %0d expected 4", q_sym.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_sym[i] !== 2'(i) || q_err[i] !== 18'sd0) begin
          errors++;
          $display("FAIL levels[%0d]: got sym=%0d err=%0d expected sym=%0d err=0", i, q_sym[i], q_err[i], i);
        end
      end
    end
    checks++;
    if (ref_level !== 18'sd65536 || ref_valid !== 1'b0) begin
      errors++; $display("FAIL levels_ref: got %0d/%0b expected 65536/0", ref_level, ref_valid);
    end
  endtask

  task automatic test_boundaries();
    logic signed [17:0] xs[4]  = '{18'sd65536, 18'sd0, -18'sd65536, -18'sd131072};
    logic [1:0]         es[4]  = '{2'b11, 2'b10, 2'b00, 2'b00};
    logic signed [17:0] ee[4]  = '{-18'sd32768, -18'sd32768, 18'sd32768, -18'sd32768};
    q_sym.delete(); q_err.delete(); q_cyc.delete();
    for (int i = 0; i < 4; i++) send_sym(xs[i], 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (q_sym.size() != 4) begin
      errors++; $display("FAIL bound_count: got %0d expected 4", q_sym.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_sym[i] !== es[i] || q_err[i] !== ee[i]) begin
          errors++;
          $display("FAIL bound[%0d]: got sym=%0d err=%0d expected sym=%0d err=%0d", i, q_sym[i], q_err[i], es[i], ee[i]);
        end
      end
    end
  endtask

  task automatic test_abs_sat();
    apply_reset();
    for (int i = 0; i < 16; i++) send_sym(-18'sd131072, 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (ref_level !== 18'sd131071 || ref_valid !== 1'b1) begin
      errors++; $display("FAIL abs_sat_ref: got %0d/%0b expected 131071/1", ref_level, ref_valid);
    end
  endtask

  task automatic test_adapt();
    logic signed [17:0] pat[4] = '{18'sd16384, -18'sd16384, 18'sd49152, -18'sd49152};
    apply_reset();
    for (int i = 0; i < 15; i++) send_sym(pat[i % 4], 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (ref_level !== 18'sd65536 || ref_valid !== 1'b0) begin
      errors++; $display("FAIL adapt_before: got %0d/%0b expected 65536/0", ref_level, ref_valid);
    end
    q_sym.delete(); q_err.delete(); q_cyc.delete();
    send_sym(pat[3], 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (ref_level !== 18'sd32768 || ref_valid !== 1'b1) begin
      errors++; $display("FAIL adapt_ref: got %0d/%0b expected 32768/1", ref_level, ref_valid);
    end
    checks++;
    if (q_sym.size() != 1 || q_sym[0] !== 2'b01 || q_err[0] !== -18'sd16384) begin
      errors++; $display("FAIL adapt_old_ref: got n=%0d sym=%0d err=%0d expected 1 1 -16384", q_sym.size(), sym_out, err);
    end
    send_sym(18'sd49152, 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (sym_out !== 2'b11 || err !== 18'sd0) begin
      errors++; $display("FAIL adapt_17th: got sym=%0d err=%0d expected 3 0", sym_out, err);
    end
  endtask

  task automatic test_phase();
    q_sym.delete(); q_err.delete(); q_cyc.delete();
    phase = 2'd2;
    send_sym(18'sd0, 18'sd4096, 18'sd8192, 18'sd12288);
    send_sym(18'sd0, 18'sd4096, 18'sd8192, 18'sd12288);
    strobe(1'b1, 18'sd0);
    phase = 2'd3;
    strobe(1'b0, 18'sd4096);
    strobe(1'b0, 18'sd8192);
    strobe(1'b0, 18'sd12288);
    @(negedge clk);
    @(negedge clk);
    send_sym(18'sd0, 18'sd4096, 18'sd8192, 18'sd12288);
    phase = 2'd0;
    checks++;
    if (q_err.size() != 4) begin
      errors++; $display("FAIL phase_count: got %0d expected 4", q_err.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic signed [17:0] ee;
        ee = (i < 2) ? -18'sd8192 : -18'sd4096;
        checks++;
        if (q_sym[i] !== 2'b10 || q_err[i] !== ee) begin
          errors++;
          $display("FAIL phase[%0d]: got sym=%0d err=%0d expected sym=2 err=%0d", i, q_sym[i], q_err[i], ee);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    q_sym.delete(); q_err.delete(); q_cyc.delete();
    phase = 2'd0;
    strobe(1'b1, 18'sd98304);
    phase = 2'd1;
    strobe(1'b0, -18'sd98304);
    strobe(1'b0, 18'sd0);
    strobe(1'b0, 18'sd0);
    phase = 2'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q_sym.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d expected 2", q_sym.size());
    end else begin
      checks++;
      if (q_sym[0] !== 2'b11 || q_err[0] !== 18'sd49152 || q_sym[1] !== 2'b00 || q_err[1] !== -18'sd49152) begin
        errors++;
        $display("FAIL b2b_values: got %0d/%0d %0d/%0d expected 3/49152 0/-49152", q_sym[0], q_err[0], q_sym[1], q_err[1]);
      end
      checks++;
      if (q_cyc[1] - q_cyc[0] != 1) begin
        errors++; $display("FAIL b2b_spacing: got %0d expected 1", q_cyc[1] - q_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 6; i++) send_sym(18'sd131071, 18'sd0, 18'sd0, 18'sd0);
    strobe(1'b1, 18'sd131071);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (sym_out !== 2'd0 || sym_valid !== 1'b0 || err !== 18'sd0 ||
        ref_level !== 18'sd65536 || ref_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got sym=%0d v=%0b err=%0d ref=%0d rv=%0b expected 0 0 0 65536 0",
               sym_out, sym_valid, err, ref_level, ref_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    q_sym.delete(); q_err.delete(); q_cyc.delete();
    for (int i = 0; i < 15; i++) send_sym(18'sd16384, 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (q_sym.size() != 15 || q_sym[0] !== 2'b10 || q_err[0] !== -18'sd16384 || ref_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_first: got n=%0d rv=%0b expected 15 0", q_sym.size(), ref_valid);
    end
    send_sym(18'sd16384, 18'sd0, 18'sd0, 18'sd0);
    checks++;
    if (ref_level !== 18'sd16384 || ref_valid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_avg: got %0d/%0b expected 16384/1", ref_level, ref_valid);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_levels();
    test_boundaries();
    test_abs_sat();
    test_adapt();
    test_phase();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ask4_downsample_slicer.md
Name: ask4_downsample_slicer

Overview:
- Sits directly downstream of the time-shared polyphase matched filter.
- Takes the filter's 1s17 sample stream at the sample rate, 4 samples per symbol.
- Keeps one sample per symbol at a selectable phase and slices it to a 4-ASK symbol.
- Tracks the decision reference level adaptively from the average magnitude, and outputs the slicer error for MER/eye measurement.

Parameters:
- SPS, 4: samples per symbol; phase counter modulus.
- LOG2_AVG, 4: log2 of the number of symbols averaged per reference update (16).
- INIT_REF, 65536: ref_level before the first average completes (1s17, 0.5).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sym_clk_en  input  1  symbol strobe; always coincides with a sam_clk_en cycle
- sam_clk_en  input  1  sample strobe, one clk wide
- phase  input  2  sample index within the symbol to keep (0..SPS-1)
- x_in  input  18  signed 1s17 matched-filter output
- sym_out  output  2  decision: 00=-3a, 01=-a, 10=+a, 11=+3a
- sym_valid  output  1  one-clk pulse when sym_out/err update
- ref_level  output  18  signed 1s17 decision threshold, equal to 2a
- ref_valid  output  1  sticky; set after the first full average
- err  output  18  signed 1s17 slicer error, x minus the reconstructed level

Behaviour:
- Reset (async, any time, including mid-block): sym_out=0, sym_valid=0, err=0, ref_level=INIT_REF, ref_valid=0; phase counter, sample register, accumulator and symbol count all 0.
- Sample index
  - In a cycle with sam_clk_en: idx = 0 if sym_clk_en, else cnt.
  - cnt <= (idx+1) mod SPS on that cycle; cnt holds otherwise.
  - After reset, the first sam_clk_en without sym_clk_en is idx 0.
- Capture: on sam_clk_en with idx==phase, sample register <= x_in (edge N).
  - phase is sampled combinationally each strobe; a change takes effect at the next strobe.
  - If phase changes mid-symbol, zero or two captures may occur in that symbol; each capture is processed.
- Slicer (registered at edge N+1, so sym_valid is high during the cycle after edge N+1). With s = captured sample and r = ref_level:
  - s >= r -> 11
  - else s >= 0 -> 10
  - else s > -r -> 01
  - else -> 00
- Reconstruction levels: 11 -> 3r/2, 10 -> r/2, 01 -> -r/2, 00 -> -3r/2.
  - r/2 is an arithmetic shift right by 1; 3r/2 = r + (r>>>1).
  - Computed in 20 bits.
- err = s - recon, computed in 20 bits and saturated to [-131072, 131071].
- Reference tracking
  - Each capture adds |s| to a (18+LOG2_AVG)-bit unsigned accumulator.
  - |-131072| saturates to 131071.
  - The symbol counter counts captures mod 2^LOG2_AVG.
  - On the capture that makes the count wrap to 0: ref_level <= (acc + |s|) >> LOG2_AVG, ref_valid <= 1, and acc <= 0 (the next block starts fresh).
  - The new ref_level first affects the decision of the following capture. The current capture is sliced with the old r.
- Multiple strobes: sam_clk_en may be back-to-back. Consecutive captures are pipelined, one result per capture.
- No output changes except on capture-driven edges; outputs hold between symbols.

Test Plan:
- Reset, phase=0, sym_clk_en every 4th sam_clk_en, x_in=98304 at idx 0 -> sym_out=11, err=0, sym_valid pulses once per symbol, 2 clks after the capturing strobe.
- x_in sequence -98304, -32768, 32768, 98304 on the kept samples, with ref=65536 -> sym_out 00, 01, 10, 11, err=0 each.
- Boundaries with r=65536:
  - s=65536 -> 11, err=-32768
  - s=0 -> 10, err=-32768
  - s=-65536 -> 00, err=32768
  - s=-131072 -> 00, err=-32768; accumulator adds 131071.
- Reference adaptation:
  - 16 symbols alternating ±16384/±49152 -> after the 16th capture, ref_level=32768 and ref_valid=1.
  - The 17th symbol at 49152 -> 11, err=0.
- Phase select: x_in = 4096*idx within each symbol, phase=2 -> every capture equals 8192. Switching phase to 3 mid-run -> captures equal 12288 from the next strobe.
- Reset asserted mid-block after 7 captures -> all outputs at reset values immediately. The next 16 captures produce a fresh average with no residue from the 7.
